// File: rtl/mc14599_out_latch.sv
// mc14599_out_latch: 8-bit addressable output latch with a capture/commit pipeline and pending-write bypass.
// Optional self-clearing pulse bits are built only when OUT_LATCH_PULSE_EN is defined.
module mc14599_out_latch #(
  parameter logic       CHIP_SEL   = 1'b1,
  parameter int         CNT_W      = 8,
  parameter int         PULSE_LEN  = 4,
  parameter logic [7:0] PULSE_MASK = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic             cs,
  input  logic [2:0]       addr,
  input  logic             din,
  input  logic             clr,
  output logic [7:0]       q,
  output logic             rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] wr_count,
  output logic             busy
);

  logic             sel_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             hit_s;
  logic             rd_bit_s;
  logic [7:0]       q_nxt_s;
  logic [7:0]       q_r;
  logic             pend_v_r;
  logic [2:0]       pend_addr_r;
  logic             pend_data_r;
  logic             rd_data_r;
  logic             rd_valid_r;
  logic [CNT_W-1:0] wr_count_r;

  // Qualify strobes with chip select and pick the readback source (pending write wins on address hit)
  always_comb begin
    sel_s    = (cs == CHIP_SEL);
    wr_acc_s = wr & sel_s;
    rd_acc_s = rd & sel_s;
    hit_s    = pend_v_r & (pend_addr_r == addr);
    if (hit_s) begin
      rd_bit_s = pend_data_r;
    end else begin
      rd_bit_s = q_r[addr];
    end
  end

`ifdef OUT_LATCH_PULSE_EN
  logic [7:0][7:0] cnt_r;
  logic [7:0][7:0] cnt_nxt_s;

  // Commit the pending write, then age the pulse-mode bits; a fresh commit overrides the aging
  always_comb begin
    q_nxt_s = q_r;
    if (pend_v_r) begin
      q_nxt_s[pend_addr_r] = pend_data_r;
    end else begin
      q_nxt_s = q_r;
    end
    for (int i = 0; i < 8; i++) begin
      cnt_nxt_s[i] = 8'd0;
      if (!PULSE_MASK[i]) begin
        cnt_nxt_s[i] = 8'd0;
      end else if (pend_v_r && (pend_addr_r == 3'(i))) begin
        if (pend_data_r) begin
          cnt_nxt_s[i] = 8'(PULSE_LEN);
        end else begin
          cnt_nxt_s[i] = 8'd0;
        end
      end else if (cnt_r[i] == 8'd1) begin
        q_nxt_s[i]   = 1'b0;
        cnt_nxt_s[i] = 8'd0;
      end else if (cnt_r[i] != 8'd0) begin
        cnt_nxt_s[i] = cnt_r[i] - 8'd1;
      end else begin
        cnt_nxt_s[i] = 8'd0;
      end
    end
  end

  // Pulse counters; reset and clr both zero them
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  logic unused_pulse_cfg_s;
  assign unused_pulse_cfg_s = ^{PULSE_MASK, 8'(PULSE_LEN)};

  // Commit the pending write into the level latches
  always_comb begin
    q_nxt_s = q_r;
    if (pend_v_r) begin
      q_nxt_s[pend_addr_r] = pend_data_r;
    end else begin
      q_nxt_s = q_r;
    end
  end
`endif

  // Capture/commit pipeline, latch state, write counter and readback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r         <= 8'h00;
      pend_v_r    <= 1'b0;
      pend_addr_r <= 3'd0;
      pend_data_r <= 1'b0;
      rd_data_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      wr_count_r  <= '0;
    end else if (clr) begin
      // Pending and same-edge writes are dropped; a same-edge read sees the cleared latch
      q_r        <= 8'h00;
      pend_v_r   <= 1'b0;
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= 1'b0;
      end
    end else begin
      q_r      <= q_nxt_s;
      pend_v_r <= wr_acc_s;
      if (pend_v_r) begin
        wr_count_r <= wr_count_r + CNT_W'(1'b1);
      end
      if (wr_acc_s) begin
        pend_addr_r <= addr;
        pend_data_r <= din;
      end
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= rd_bit_s;
      end
    end
  end

  assign q        = q_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign wr_count = wr_count_r;
  assign busy     = pend_v_r;

endmodule

// File: tb/tb_mc14599_out_latch.sv
// Table-driven, scoreboarded bench for mc14599_out_latch; a second instance with bit 0 in pulse mode
// covers the OUT_LATCH_PULSE_EN behaviour (level behaviour expected when the macro is undefined).
module tb_mc14599_out_latch;

  typedef struct {
    logic       reset, clr, wr, rd, cs;
    logic [2:0] addr;
    logic       din;
    logic [7:0] q;
    logic       busy, rd_valid, rd_data;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, wr, rd, cs, din, clr;
  logic [2:0] addr;
  logic [7:0] q, q_p, wr_count, wr_count_p;
  logic       rd_data, rd_valid, busy, rd_data_p, rd_valid_p, busy_p;

  vec_t       vecs[$];
  vec_t       sb[$];
  logic [1:0] psb[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mc14599_out_latch #(.CHIP_SEL(1'b1), .CNT_W(8), .PULSE_LEN(4), .PULSE_MASK(8'h00)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .cs(cs), .addr(addr), .din(din), .clr(clr),
    .q(q), .rd_data(rd_data), .rd_valid(rd_valid), .wr_count(wr_count), .busy(busy));

  mc14599_out_latch #(.CHIP_SEL(1'b1), .CNT_W(8), .PULSE_LEN(4), .PULSE_MASK(8'h01)) dut_p (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .cs(cs), .addr(addr), .din(din), .clr(clr),
    .q(q_p), .rd_data(rd_data_p), .rd_valid(rd_valid_p), .wr_count(wr_count_p), .busy(busy_p));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ctl = {reset, clr, wr, rd, cs}; e = {busy, rd_valid, rd_data}
  function automatic vec_t mk(input logic [4:0] ctl, input logic [2:0] a, input logic d,
                              input logic [7:0] eq, input logic [2:0] e, input logic [7:0] ec);
    vec_t v;
    {v.reset, v.clr, v.wr, v.rd, v.cs} = ctl;
    v.addr = a;
    v.din  = d;
    v.q    = eq;
    {v.busy, v.rd_valid, v.rd_data} = e;
    v.cnt  = ec;
    return v;
  endfunction

  task automatic add(input logic [4:0] ctl, input logic [2:0] a, input logic d,
                     input logic [7:0] eq, input logic [2:0] e, input logic [7:0] ec);
    vecs.push_back(mk(ctl, a, d, eq, e, ec));
  endtask

  task automatic drive(input vec_t v);
    reset = v.reset; clr = v.clr; wr = v.wr; rd = v.rd; cs = v.cs; addr = v.addr; din = v.din;
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("q", {24'd0, q}, {24'd0, e.q});
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.rd_valid});
      chk("rd_data", {31'd0, rd_data}, {31'd0, e.rd_data});
      chk("wr_count", {24'd0, wr_count}, {24'd0, e.cnt});
    end
  endtask

  // One cycle of the pulse sequence: optional write of 1 to bit 0, then check both instances' bit 0
  task automatic pstep(input logic w, input logic exp_pulse, input logic exp_level);
    logic [1:0] e;
    drive(mk({2'b00, w, 1'b0, 1'b1}, 3'd0, 1'b1, 8'h00, 3'b000, 8'd0));
    psb.push_back({exp_pulse, exp_level});
    @(posedge clk);
    #1;
    e = psb.pop_front();
    chk("pulse_q0", {31'd0, q_p[0]}, {31'd0, e[1]});
    chk("level_q0", {31'd0, q[0]}, {31'd0, e[0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] w1, p1, l1;
    logic [7:0] w2, p2, l2;

    // Reset, single write latency
    add(5'b10001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0);
    add(5'b00001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0);
    add(5'b00101, 3'd5, 1'b1, 8'h00, 3'b100, 8'd0);
    add(5'b00001, 3'd0, 1'b0, 8'h20, 3'b000, 8'd1);
    // Back-to-back burst, addr 0..7, din 1,0,1,0,...
    add(5'b10001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0);
    add(5'b00101, 3'd0, 1'b1, 8'h00, 3'b100, 8'd0);
    add(5'b00101, 3'd1, 1'b0, 8'h01, 3'b100, 8'd1);
    add(5'b00101, 3'd2, 1'b1, 8'h01, 3'b100, 8'd2);
    add(5'b00101, 3'd3, 1'b0, 8'h05, 3'b100, 8'd3);
    add(5'b00101, 3'd4, 1'b1, 8'h05, 3'b100, 8'd4);
    add(5'b00101, 3'd5, 1'b0, 8'h15, 3'b100, 8'd5);
    add(5'b00101, 3'd6, 1'b1, 8'h15, 3'b100, 8'd6);
    add(5'b00101, 3'd7, 1'b0, 8'h55, 3'b100, 8'd7);
    add(5'b00001, 3'd0, 1'b0, 8'h55, 3'b000, 8'd8);
    // Bypass read, same-edge write invisible to read
    add(5'b00101, 3'd3, 1'b1, 8'h55, 3'b100, 8'd8);
    add(5'b00011, 3'd3, 1'b0, 8'h5D, 3'b011, 8'd9);
    add(5'b00111, 3'd3, 1'b0, 8'h5D, 3'b111, 8'd9);
    add(5'b00001, 3'd0, 1'b0, 8'h55, 3'b001, 8'd10);
    add(5'b00101, 3'd0, 1'b0, 8'h55, 3'b101, 8'd10);
    add(5'b00011, 3'd0, 1'b0, 8'h54, 3'b010, 8'd11);
    add(5'b00011, 3'd6, 1'b0, 8'h54, 3'b011, 8'd11);
    add(5'b00001, 3'd0, 1'b0, 8'h54, 3'b001, 8'd11);
    // Chip select mismatch ignores wr and rd
    add(5'b00110, 3'd2, 1'b1, 8'h54, 3'b001, 8'd11);
    add(5'b00110, 3'd0, 1'b1, 8'h54, 3'b001, 8'd11);
    add(5'b00001, 3'd0, 1'b0, 8'h54, 3'b001, 8'd11);
    // Fill to FF, leave a write pending, then clr with same-edge wr and rd
    add(5'b00101, 3'd0, 1'b1, 8'h54, 3'b101, 8'd11);
    add(5'b00101, 3'd1, 1'b1, 8'h55, 3'b101, 8'd12);
    add(5'b00101, 3'd2, 1'b1, 8'h57, 3'b101, 8'd13);
    add(5'b00101, 3'd3, 1'b1, 8'h57, 3'b101, 8'd14);
    add(5'b00101, 3'd4, 1'b1, 8'h5F, 3'b101, 8'd15);
    add(5'b00101, 3'd5, 1'b1, 8'h5F, 3'b101, 8'd16);
    add(5'b00101, 3'd6, 1'b1, 8'h7F, 3'b101, 8'd17);
    add(5'b00101, 3'd7, 1'b1, 8'h7F, 3'b101, 8'd18);
    add(5'b00001, 3'd0, 1'b0, 8'hFF, 3'b001, 8'd19);
    add(5'b00101, 3'd2, 1'b0, 8'hFF, 3'b101, 8'd19);
    add(5'b01111, 3'd0, 1'b1, 8'h00, 3'b010, 8'd19);
    add(5'b00001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd19);
    // Reset mid-operation discards the pending write
    add(5'b00101, 3'd1, 1'b1, 8'h00, 3'b100, 8'd19);
    add(5'b00111, 3'd1, 1'b1, 8'h02, 3'b111, 8'd20);
    add(5'b10101, 3'd6, 1'b1, 8'h00, 3'b000, 8'd0);
    add(5'b00001, 3'd4, 1'b0, 8'h00, 3'b000, 8'd0);

    foreach (vecs[i]) step(vecs[i]);

    // wr_count wrap: 256 commits bring it back to 0
    step(mk(5'b10001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0));
    for (int i = 0; i < 255; i++) begin
      drive(mk(5'b00101, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0));
      @(posedge clk);
      #1;
    end
    step(mk(5'b00101, 3'd0, 1'b0, 8'h00, 3'b100, 8'd255));
    step(mk(5'b00001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0));

    // Pulse-mode bit 0: single pulse, then a restart by a second commit
    w1 = 7'b0000001;
    w2 = 8'b00000101;
    l1 = 7'b1111110;
    l2 = 8'b11111110;
`ifdef OUT_LATCH_PULSE_EN
    p1 = 7'b0011110;
    p2 = 8'b01111110;
`else
    p1 = 7'b1111110;
    p2 = 8'b11111110;
`endif
    step(mk(5'b10001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0));
    for (int i = 0; i < 7; i++) pstep(w1[i], p1[i], l1[i]);
    step(mk(5'b10001, 3'd0, 1'b0, 8'h00, 3'b000, 8'd0));
    for (int i = 0; i < 8; i++) pstep(w2[i], p2[i], l2[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
